sipo_packer: RTL and testbench

- Serial-in/parallel-out packer.
- Consumes the narrow beat stream at the output of a delay-line stage (DATA_WIDTH-bit beats, one per valid cycle) and assembles WORD_WIDTH-bit words.
- Word alignment comes from a sync marker.
- Presents each word on a one-entry valid/ready output register for downstream framing logic.

---
 rtl/sipo_packer.sv | 114 +++++++++++
 tb/tb_sipo_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_packer.sv
// Serial-in/parallel-out packer: assembles IN_WIDTH-bit beats into WORD_WIDTH-bit words
// aligned by a sync marker, presented on a one-entry valid/ready output register.
module sipo_packer #(
  parameter int IN_WIDTH   = 1,
  parameter int WORD_WIDTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  in_sync,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic                  sync_err,
  output logic                  overflow
);

  localparam int BEATS = WORD_WIDTH / IN_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {HUNT = 1'b0, PACK = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  locked_q, locked_d;
  logic                  sync_err_q, sync_err_d;
  logic                  overflow_q, overflow_d;

  logic [CNT_W-1:0]      slot;
  logic [WORD_WIDTH-1:0] merged;

  // A sync beat always restarts at slice 0 on a clean accumulator.
  always_comb begin
    slot   = in_sync ? '0 : cnt_q;
    merged = in_sync ? '0 : acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (slot == CNT_W'(k)) begin
        merged[((MSB_FIRST != 0) ? (WORD_WIDTH - (k + 1) * IN_WIDTH) : (k * IN_WIDTH)) +: IN_WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    sync_err_d  = 1'b0;
    overflow_d  = 1'b0;

    if (in_valid) begin
      if (in_sync) begin
        sync_err_d = (state_q == PACK) && (cnt_q != '0);
        state_d    = PACK;
        cnt_d      = CNT_W'(1);
        acc_d      = merged;
      end else if (state_q == PACK) begin
        if (cnt_q == LAST_BEAT) begin
          cnt_d = '0;
          acc_d = '0;
          // Load when empty or when the held word drains this same cycle.
          if (!out_valid_q || out_ready) begin
            out_data_d  = merged;
            out_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = merged;
        end
      end
    end

    locked_d = (state_d == PACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sipo_packer.sv
// Bench for sipo_packer: an MSB-first 1-bit instance and an LSB-first 2-bit instance share
// control inputs and are checked every cycle against a word-level reference model.
module tb_sipo_packer;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_sync, out_ready;
  logic       a_in;
  logic [1:0] b_in;
  logic [7:0] a_od, b_od;
  logic       a_ov, a_lk, a_se, a_of;
  logic       b_ov, b_lk, b_se, b_of;

  always #5 clk = ~clk;

  sipo_packer #(.IN_WIDTH(1), .WORD_WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in), .in_valid(in_valid), .in_sync(in_sync),
    .out_data(a_od), .out_valid(a_ov), .out_ready(out_ready),
    .locked(a_lk), .sync_err(a_se), .overflow(a_of));

  sipo_packer #(.IN_WIDTH(2), .WORD_WIDTH(8), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in), .in_valid(in_valid), .in_sync(in_sync),
    .out_data(b_od), .out_valid(b_ov), .out_ready(out_ready),
    .locked(b_lk), .sync_err(b_se), .overflow(b_of));

  int n_vec = 0;
  int n_err = 0;
  int cnt_se_a, cnt_se_b, cnt_of_a, cnt_ov_a;

  // Reference model: beats accumulated arithmetically, word emitted once BEATS beats seen.
  bit       m_lk[2], m_ov[2], m_se[2], m_of[2];
  int       m_n[2], m_acc[2];
  logic [7:0] m_od[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int w, input bit msb, input int d,
                            input bit r, input bit v, input bit s, input bit rdy);
    int beats;
    bit ov;
    beats = 8 / w;
    ov = m_ov[i];
    if (r) begin
      m_lk[i] = 0; m_n[i] = 0; m_acc[i] = 0; m_ov[i] = 0; m_od[i] = 8'h00;
      m_se[i] = 0; m_of[i] = 0;
      return;
    end
    m_se[i] = 0;
    m_of[i] = 0;
    if (ov && rdy) m_ov[i] = 0;
    if (!v) return;
    if (s) begin
      if (m_lk[i] && m_n[i] != 0) m_se[i] = 1;
      m_lk[i] = 1; m_n[i] = 1; m_acc[i] = d;
      return;
    end
    if (!m_lk[i]) return;
    if (msb) m_acc[i] = m_acc[i] * (1 << w) + d;
    else     m_acc[i] = m_acc[i] + d * (1 << (m_n[i] * w));
    m_n[i]++;
    if (m_n[i] == beats) begin
      m_n[i] = 0;
      if (!ov || rdy) begin
        m_ov[i] = 1;
        m_od[i] = 8'(m_acc[i]);
      end else begin
        m_of[i] = 1;
      end
      m_acc[i] = 0;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input logic da,
                      input logic [1:0] db, input bit rdy);
    rst = r; in_valid = v; in_sync = s; a_in = da; b_in = db; out_ready = rdy;
    model_step(0, 1, 1'b1, int'(da), r, v, s, rdy);
    model_step(1, 2, 1'b0, int'(db), r, v, s, rdy);
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b v=%0b s=%0b rdy=%0b | a ov=%0b od=%h lk=%0b se=%0b of=%0b | b ov=%0b od=%h lk=%0b se=%0b of=%0b",
             $time, r, v, s, rdy, a_ov, a_od, a_lk, a_se, a_of, b_ov, b_od, b_lk, b_se, b_of);
    check("a_out_valid", 32'(a_ov), 32'(m_ov[0]));
    check("a_out_data",  32'(a_od), 32'(m_od[0]));
    check("a_locked",    32'(a_lk), 32'(m_lk[0]));
    check("a_sync_err",  32'(a_se), 32'(m_se[0]));
    check("a_overflow",  32'(a_of), 32'(m_of[0]));
    check("b_out_valid", 32'(b_ov), 32'(m_ov[1]));
    check("b_out_data",  32'(b_od), 32'(m_od[1]));
    check("b_locked",    32'(b_lk), 32'(m_lk[1]));
    check("b_sync_err",  32'(b_se), 32'(m_se[1]));
    check("b_overflow",  32'(b_of), 32'(m_of[1]));
    cnt_se_a += int'(a_se);
    cnt_se_b += int'(b_se);
    cnt_of_a += int'(a_of);
    cnt_ov_a += int'(a_ov);
  endtask

  task automatic send_word_a(input logic [7:0] w, input bit rdy, input bit rdy_last);
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b1, k == 0, w[7-k], 2'($urandom), (k == 7) ? rdy_last : rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  typedef struct {
    bit         r, v, s, d, rdy;
    bit         e_ov;
    logic [7:0] e_od;
    bit         e_lk, e_se, e_of;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, bit s, bit d, bit rdy,
                              bit e_ov, logic [7:0] e_od, bit e_lk);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d; t.rdy = rdy;
    t.e_ov = e_ov; t.e_od = e_od; t.e_lk = e_lk; t.e_se = 0; t.e_of = 0;
    return t;
  endfunction

  vec_t tbl[12];

  initial begin
    // Basic MSB-first pack of 0xA5 on dut_a.
    tbl[0]  = mk(1, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[1]  = mk(1, 0, 0, 0, 1, 0, 8'h00, 0);
    tbl[2]  = mk(0, 1, 1, 1, 1, 0, 8'h00, 1);
    tbl[3]  = mk(0, 1, 0, 0, 1, 0, 8'h00, 1);
    tbl[4]  = mk(0, 1, 0, 1, 1, 0, 8'h00, 1);
    tbl[5]  = mk(0, 1, 0, 0, 1, 0, 8'h00, 1);
    tbl[6]  = mk(0, 1, 0, 0, 1, 0, 8'h00, 1);
    tbl[7]  = mk(0, 1, 0, 1, 1, 0, 8'h00, 1);
    tbl[8]  = mk(0, 1, 0, 0, 1, 0, 8'h00, 1);
    tbl[9]  = mk(0, 1, 0, 1, 1, 1, 8'hA5, 1);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, 8'hA5, 1);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 8'hA5, 1);

    cnt_se_a = 0; cnt_se_b = 0; cnt_of_a = 0; cnt_ov_a = 0;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, {1'b0, tbl[i].d}, tbl[i].rdy);
      check("tbl_out_valid", 32'(a_ov), 32'(tbl[i].e_ov));
      check("tbl_out_data",  32'(a_od), 32'(tbl[i].e_od));
      check("tbl_locked",    32'(a_lk), 32'(tbl[i].e_lk));
      check("tbl_sync_err",  32'(a_se), 32'(tbl[i].e_se));
      check("tbl_overflow",  32'(a_of), 32'(tbl[i].e_of));
    end

    // HUNT discard then LSB-first pack of 0x39 on dut_b.
    do_reset();
    cnt_se_b = 0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    check("lsb_word", 32'(b_od), 32'h39);
    check("lsb_valid", 32'(b_ov), 32'd1);
    check("lsb_no_sync_err", 32'(cnt_se_b), 32'd0);

    // Mid-word resync on dut_a: partial word discarded, one sync_err pulse.
    do_reset();
    cnt_se_a = 0; cnt_ov_a = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'b1);
    send_word_a(8'h3C, 1'b1, 1'b1);
    check("resync_word", 32'(a_od), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("resync_err_pulses", 32'(cnt_se_a), 32'd1);
    check("resync_valid_cycles", 32'(cnt_ov_a), 32'd1);

    // Backpressure: second word dropped with one overflow pulse, then drain.
    do_reset();
    send_word_a(8'h11, 1'b0, 1'b0);
    check("bp_first_valid", 32'(a_ov), 32'd1);
    cnt_of_a = 0;
    send_word_a(8'h22, 1'b0, 1'b0);
    check("bp_held_word", 32'(a_od), 32'h11);
    check("bp_overflow_pulses", 32'(cnt_of_a), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("bp_drained", 32'(a_ov), 32'd0);

    // Simultaneous drain and load.
    do_reset();
    send_word_a(8'h11, 1'b0, 1'b0);
    cnt_of_a = 0;
    send_word_a(8'h22, 1'b0, 1'b1);
    check("swap_valid", 32'(a_ov), 32'd1);
    check("swap_word", 32'(a_od), 32'h22);
    check("swap_no_overflow", 32'(cnt_of_a), 32'd0);

    // Reset mid-word with a held output word.
    do_reset();
    send_word_a(8'h11, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, k == 0, 1'($urandom), 2'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    check("rst_valid", 32'(a_ov), 32'd0);
    check("rst_locked", 32'(a_lk), 32'd0);
    check("rst_data", 32'(a_od), 32'd0);
    send_word_a(8'h5A, 1'b1, 1'b1);
    check("post_rst_word", 32'(a_od), 32'h5A);
    check("post_rst_valid", 32'(a_ov), 32'd1);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
           1'($urandom), 2'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
